// File: rtl/ft232h_dir_scheduler_if.sv
// Purpose: groups the scheduler's status inputs, byte strobes and command/status outputs.
// Ports: enable, RXFn, TXEn, rdempty, wrfull, rx_strobe, tx_strobe (to scheduler);
//        CMD, state_o, burst_cnt (from scheduler). slave = scheduler side, master = driver side.
interface ft232h_dir_scheduler_if;
    logic       enable;
    logic       RXFn;
    logic       TXEn;
    logic       rdempty;
    logic       wrfull;
    logic       rx_strobe;
    logic       tx_strobe;
    logic [1:0] CMD;
    logic [2:0] state_o;
    logic [7:0] burst_cnt;

    modport master (
        output enable, RXFn, TXEn, rdempty, wrfull, rx_strobe, tx_strobe,
        input  CMD, state_o, burst_cnt
    );

    modport slave (
        input  enable, RXFn, TXEn, rdempty, wrfull, rx_strobe, tx_strobe,
        output CMD, state_o, burst_cnt
    );
endinterface

// File: rtl/ft232h_dir_scheduler.sv
// Purpose: FT232H sync-FIFO direction scheduler; issues CMD 00 idle / 01 RX / 10 TX / 11 SIWU flush.
// Latency: grant CMD one cycle after a side becomes ready in IDLE; TURN_CYCLES+1 after a grant ends.
// Backpressure: a grant ends on burst limit, own side not ready (RXFn/wrfull, TXEn/rdempty) or enable low.
// Ports: clk, RSTn (async active-low), bus (slave modport: status/strobes in, CMD/state_o/burst_cnt out).
// Optional: define FT232H_SIWU_FLUSH_EN to add the idle-timeout SIWU flush request (FLUSH_TIMEOUT).
module ft232h_dir_scheduler #(
    parameter int MAX_BURST   = 64,
    parameter int TURN_CYCLES = 2
`ifdef FT232H_SIWU_FLUSH_EN
    ,
    parameter int FLUSH_TIMEOUT = 255
`endif
) (
    input  logic                         clk,
    input  logic                         RSTn,
    ft232h_dir_scheduler_if.slave        bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RX    = 3'd1,
        S_TX    = 3'd2,
        S_TURN  = 3'd3,
        S_FLUSH = 3'd4
    } state_t;

    localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);
    localparam logic [3:0] TURN_LAST  = 4'(TURN_CYCLES - 1);

    state_t     state_q, state_d;
    state_t     arb_state;
    logic [1:0] cmd_q, cmd_d;
    logic [7:0] burst_cnt_q;
    logic [3:0] turn_cnt_q;
    logic       last_dir_rx_q;   // 1 = last grant was RX
    logic       rx_ready, tx_ready;
    logic       grant;

    assign rx_ready = ~bus.RXFn & ~bus.wrfull;
    assign tx_ready = ~bus.TXEn & ~bus.rdempty;

`ifdef FT232H_SIWU_FLUSH_EN
    localparam logic [15:0] FLUSH_LAST = 16'(FLUSH_TIMEOUT);
    logic        flush_pending_q;
    logic [15:0] flush_tmr_q;
    logic        flush_due;

    // Pending is also required so a saturated timer cannot trigger a second SIWU.
    assign flush_due = flush_pending_q && (flush_tmr_q == FLUSH_LAST);
`endif

    // Arbitration result shared by IDLE and the last TURN cycle; ties go to the
    // direction not served last.
    always_comb begin
        arb_state = S_IDLE;
        if (bus.enable) begin
            if (rx_ready && tx_ready)
                arb_state = last_dir_rx_q ? S_TX : S_RX;
            else if (rx_ready)
                arb_state = S_RX;
            else if (tx_ready)
                arb_state = S_TX;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (arb_state != S_IDLE)
                    state_d = arb_state;
`ifdef FT232H_SIWU_FLUSH_EN
                else if (bus.enable && flush_due)
                    state_d = S_FLUSH;
`endif
            end
            S_RX: begin
                if (!bus.enable || !rx_ready || (bus.rx_strobe && burst_cnt_q == BURST_LAST))
                    state_d = S_TURN;
            end
            S_TX: begin
                if (!bus.enable || !tx_ready || (bus.tx_strobe && burst_cnt_q == BURST_LAST))
                    state_d = S_TURN;
            end
            // The final TURN cycle arbitrates directly so the bus sees exactly
            // TURN_CYCLES idle commands between grants.
            S_TURN: begin
                if (turn_cnt_q == TURN_LAST)
                    state_d = arb_state;
            end
            S_FLUSH: state_d = S_TURN;
            default: state_d = S_IDLE;
        endcase
    end

    assign grant = (state_q == S_IDLE || state_q == S_TURN) &&
                   (state_d == S_RX || state_d == S_TX);

    always_comb begin
        cmd_d = 2'b00;
        case (state_d)
            S_RX:    cmd_d = 2'b01;
            S_TX:    cmd_d = 2'b10;
            S_FLUSH: cmd_d = 2'b11;
            default: cmd_d = 2'b00;
        endcase
    end

    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            state_q       <= S_IDLE;
            cmd_q         <= 2'b00;
            burst_cnt_q   <= 8'd0;
            turn_cnt_q    <= 4'd0;
            last_dir_rx_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            turn_cnt_q <= (state_q == S_TURN) ? turn_cnt_q + 4'd1 : 4'd0;
            if (grant) begin
                burst_cnt_q   <= 8'd0;
                last_dir_rx_q <= (state_d == S_RX);
            end else if (burst_cnt_q != 8'hFF &&
                         ((state_q == S_RX && bus.rx_strobe) ||
                          (state_q == S_TX && bus.tx_strobe))) begin
                burst_cnt_q <= burst_cnt_q + 8'd1;
            end
        end
    end

`ifdef FT232H_SIWU_FLUSH_EN
    // Any TX byte, including pipeline-tail bytes during TURN, restarts the timeout.
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            flush_pending_q <= 1'b0;
            flush_tmr_q     <= 16'd0;
        end else if (bus.tx_strobe) begin
            flush_pending_q <= 1'b1;
            flush_tmr_q     <= 16'd0;
        end else if (state_d == S_FLUSH) begin
            flush_pending_q <= 1'b0;
            flush_tmr_q     <= 16'd0;
        end else if (state_q == S_IDLE && flush_pending_q && bus.rdempty &&
                     flush_tmr_q != FLUSH_LAST) begin
            flush_tmr_q <= flush_tmr_q + 16'd1;
        end
    end
`endif

    assign bus.CMD       = cmd_q;
    assign bus.state_o   = state_q;
    assign bus.burst_cnt = burst_cnt_q;

endmodule

// File: tb/tb_ft232h_dir_scheduler.sv
// Purpose: directed checks of the direction scheduler (MAX_BURST=64, TURN_CYCLES=2, FLUSH_TIMEOUT=8).
// Latency: outputs sampled 1 time unit after each rising clk edge.
// Backpressure: driven through RXFn/TXEn/wrfull/rdempty/enable from a single directed sequence.
module tb_ft232h_dir_scheduler;
    logic clk = 1'b0;
    logic RSTn;
    int   nvec = 0;
    int   nerr = 0;
    int   n;

    always #5 clk = ~clk;

    ft232h_dir_scheduler_if bus();

    ft232h_dir_scheduler #(
        .MAX_BURST(64),
        .TURN_CYCLES(2)
`ifdef FT232H_SIWU_FLUSH_EN
        ,
        .FLUSH_TIMEOUT(8)
`endif
    ) dut (
        .clk(clk),
        .RSTn(RSTn),
        .bus(bus)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp)
        else begin
            nerr++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Number of consecutive samples (starting with the current one) showing CMD == val.
    task automatic run_len(input logic [1:0] val, output int len);
        len = 0;
        while (bus.CMD === val && len < 300) begin
            len++;
            step();
        end
    endtask

    initial begin
        RSTn          = 1'b0;
        bus.enable    = 1'b1;
        bus.RXFn      = 1'b1;
        bus.TXEn      = 1'b1;
        bus.rdempty   = 1'b1;
        bus.wrfull    = 1'b0;
        bus.rx_strobe = 1'b0;
        bus.tx_strobe = 1'b0;
        step();
        step();
        chk("rst_cmd", bus.CMD, 0);
        chk("rst_state", bus.state_o, 0);
        chk("rst_burst", bus.burst_cnt, 0);

        // Reset release with RX ready: grant one cycle later.
        bus.RXFn = 1'b0;
        RSTn     = 1'b1;
        step();
        chk("t1_grant_cmd", bus.CMD, 1);
        chk("t1_grant_state", bus.state_o, 1);
        bus.rx_strobe = 1'b1;
        repeat (5) step();
        chk("t1_burst5", bus.burst_cnt, 5);
        chk("t1_still_rx", bus.CMD, 1);
        #2 RSTn = 1'b0;
        #1;
        chk("t1_async_cmd", bus.CMD, 0);
        chk("t1_async_burst", bus.burst_cnt, 0);
        chk("t1_async_state", bus.state_o, 0);
        bus.rx_strobe = 1'b0;
        bus.RXFn      = 1'b1;
        RSTn          = 1'b1;
        step();
        chk("t1_idle_after", bus.CMD, 0);

        // Both sides ready and streaming: 64 RX, 2 turn, 64 TX, 2 turn, RX.
        bus.RXFn      = 1'b0;
        bus.TXEn      = 1'b0;
        bus.rdempty   = 1'b0;
        bus.rx_strobe = 1'b1;
        bus.tx_strobe = 1'b1;
        step();
        chk("t2_first_rx", bus.CMD, 1);
        run_len(2'b01, n);
        chk("t2_rx_len", n, 64);
        chk("t2_rx_burst", bus.burst_cnt, 64);
        chk("t2_turn_state", bus.state_o, 3);
        run_len(2'b00, n);
        chk("t2_gap1", n, 2);
        chk("t2_tx_cmd", bus.CMD, 2);
        chk("t2_tx_burst0", bus.burst_cnt, 0);
        run_len(2'b10, n);
        chk("t2_tx_len", n, 64);
        run_len(2'b00, n);
        chk("t2_gap2", n, 2);
        chk("t2_back_rx", bus.CMD, 1);

        bus.RXFn      = 1'b1;
        bus.TXEn      = 1'b1;
        bus.rx_strobe = 1'b0;
        bus.tx_strobe = 1'b0;
        repeat (4) step();
        chk("t2_settle_idle", bus.state_o, 0);

        // TX grant ended early by TXEn after 10 bytes.
        bus.TXEn = 1'b0;
        step();
        chk("t3_tx_cmd", bus.CMD, 2);
        bus.tx_strobe = 1'b1;
        repeat (10) step();
        chk("t3_burst10", bus.burst_cnt, 10);
        bus.TXEn      = 1'b1;
        bus.tx_strobe = 1'b0;
        step();
        chk("t3_exit_cmd", bus.CMD, 0);
        chk("t3_exit_burst", bus.burst_cnt, 10);
        chk("t3_turn1", bus.state_o, 3);
        step();
        chk("t3_turn2", bus.state_o, 3);
        step();
        chk("t3_idle", bus.state_o, 0);

        // Only RX ready: same-direction re-grant after the turnaround.
        bus.RXFn      = 1'b0;
        bus.rx_strobe = 1'b1;
        step();
        chk("t4_grant", bus.CMD, 1);
        run_len(2'b01, n);
        chk("t4_rx_len", n, 64);
        run_len(2'b00, n);
        chk("t4_gap", n, 2);
        chk("t4_regrant", bus.CMD, 1);
        chk("t4_regrant_burst", bus.burst_cnt, 0);

        // enable low mid-burst: strobe counted, TURN, then no grant until re-enabled.
        repeat (2) step();
        chk("t6_burst2", bus.burst_cnt, 2);
        bus.enable = 1'b0;
        step();
        chk("t6_exit_cmd", bus.CMD, 0);
        chk("t6_exit_state", bus.state_o, 3);
        chk("t6_exit_burst", bus.burst_cnt, 3);
        repeat (2) step();
        chk("t6_idle", bus.state_o, 0);
        repeat (3) step();
        chk("t6_hold_cmd", bus.CMD, 0);
        chk("t6_hold_state", bus.state_o, 0);
        bus.enable = 1'b1;
        step();
        chk("t6_resume", bus.CMD, 1);

        // wrfull ends an RX grant; the byte in that cycle still counts.
        bus.wrfull = 1'b1;
        step();
        chk("wf_exit_cmd", bus.CMD, 0);
        chk("wf_exit_burst", bus.burst_cnt, 1);
        bus.RXFn      = 1'b1;
        bus.rx_strobe = 1'b0;
        bus.wrfull    = 1'b0;
        repeat (4) step();
        chk("wf_idle", bus.state_o, 0);

        // Three TX bytes then FIFO drains: SIWU flush request only when enabled.
        bus.TXEn = 1'b0;
        step();
        chk("t5_tx_cmd", bus.CMD, 2);
        bus.tx_strobe = 1'b1;
        repeat (3) step();
        chk("t5_burst3", bus.burst_cnt, 3);
        bus.tx_strobe = 1'b0;
        bus.rdempty   = 1'b1;
        step();
        chk("t5_exit_cmd", bus.CMD, 0);
`ifdef FT232H_SIWU_FLUSH_EN
        run_len(2'b00, n);
        chk("t5_quiet_len", n, 11);
        chk("t5_siwu_cmd", bus.CMD, 3);
        chk("t5_siwu_state", bus.state_o, 4);
        step();
        chk("t5_after_cmd", bus.CMD, 0);
        chk("t5_after_state", bus.state_o, 3);
        n = 0;
        repeat (40) begin
            step();
            if (bus.CMD === 2'b11) n++;
        end
        chk("t5_no_second_siwu", n, 0);
`else
        n = 0;
        repeat (40) begin
            step();
            if (bus.CMD === 2'b11) n++;
        end
        chk("t5_never_siwu", n, 0);
        chk("t5_idle_state", bus.state_o, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
